bytedecode_stream: RTL and testbench
====================================

// Module: bytedecode_stream
// PURPOSE
//  Streaming ML-KEM ByteDecode_d: unpacks a packed byte stream into 256 d-bit coefficients (d = 1..12).
//  Generalised successor of the fixed 64-bit decoder: parametrised input width and lanes per beat,
//  full valid/ready on both sides, any d in 1..12. Sits between the byte-stream front end and poly RAM/NTT.
// PARAMETERS
//  IW     64   input word width in bits; must be a multiple of 8 and divide 256 (IW <= 256)
//  NC      4   coefficient lanes per output beat; must divide 256
//  CW     12   output lane width in bits (>= 12)
//  NCOEF 256   coefficients per polynomial
// PORTS
//  i_clk           in   1      clock
//  i_rst           in   1      synchronous reset, active-high
//  i_start         in   1      start one polynomial decode; sampled in S_IDLE only
//  i_d             in   4      bits per coefficient; sampled with i_start
//  i_ibytes        in   IW     packed input; byte k = [8k+7:8k], bit j of byte k = stream bit 8k+j
//  i_ibytes_valid  in   1      input word valid
//  o_ibytes_ready  out  1      input word accepted when valid & ready
//  o_coeffs        out  NC*CW  lane k = [k*CW +: CW] = coefficient (base + k), zero-extended
//  o_coeffs_valid  out  1      output beat valid; contents held stable until accepted
//  i_coeffs_ready  in   1      downstream ready
//  o_busy          out  1      high from accepted start until o_done
//  o_done          out  1      one-cycle pulse after the last output handshake
//  o_err           out  1      one-cycle pulse: i_start with i_d == 0 or i_d > 12
// BEHAVIOUR
//  Reset, synchronous: state S_IDLE; fill = 0; all counters = 0; every output 0.
//  States: S_IDLE -> S_RUN on i_start with legal d; S_RUN -> S_DONE on the last output handshake;
//          S_DONE -> S_IDLE after 1 cycle. o_done = (state == S_DONE).
//  Illegal d: o_err pulses, state stays S_IDLE. i_start is ignored outside S_IDLE.
//  Bit buffer: BUFW = IW + NC*12 bits, LSB-first. fill is the valid-bit count.
//  o_ibytes_ready = S_RUN & (in_cnt < 256*d/IW) & (fill + IW <= BUFW - (pop ? NC*d : 0)).
//  Push appends at bit position fill. Pop removes NC*d bits from the LSB.
//  Push and pop in the same cycle: fill' = fill + IW - NC*d.
//  Output register loads when fill >= NC*d and (!o_coeffs_valid | i_coeffs_ready).
//  Lane k = buf[k*d +: d]. First beat is valid 1 cycle after the first enabling push.
//  Stall: i_coeffs_ready low keeps o_coeffs/o_coeffs_valid stable. Buffer fills, then ready drops.
//  No bits are lost.
//  Totals: exactly 256*d/IW input beats and NCOEF/NC output beats. fill == 0 at S_DONE; no residue.
//  Counters: in_cnt 0..4*12 (width clog2(256*12/8+1)); out_cnt 0..NCOEF/NC-1.
//  Last pop is at out_cnt == NCOEF/NC-1.
//  Reset mid-operation: immediate return to reset state. Partial data is discarded; no o_done.
// CONFIGURATION
//  BYTEDECODE_DECOMPRESS_EN defined: each lane = Decompress_d(x) = (x*3329 + 2^(d-1)) >> d for d < 12.
//  For d == 12 the lane is x unchanged. The multiply stays in the same cycle, so latency is unchanged.
//  Not defined: lanes carry raw x zero-extended; no multiplier is built.
// STRUCTURE
//  Shared header kyber_defs.vh: KYBER_Q = 3329, KYBER_N = 256, KYBER_DMAX = 12, state encodings
//  S_IDLE/S_RUN/S_DONE.
//  Sub-module decompress_lane (x[11:0], d[3:0] -> y[CW-1:0]), instantiated NC times under the macro.
//  The bit buffer and lane extraction stay in this module as indexed part-selects.
// TESTING
//  d=4, IW=64, NC=4, first word bytes 21 43 .. -> first beat lanes 1,2,3,4 (o_coeffs = 48'h004003002001).
//    16 input beats and 64 output beats in total, then o_done for 1 cycle.
//  d=12, bytes 01 23 45 -> coeff0 = 12'h301, coeff1 = 12'h452. 48 input beats in total.
//  d=11, random stream with i_coeffs_ready low for 10 cycles mid-run -> o_coeffs stable during stall.
//    o_ibytes_ready drops once full. Output matches the reference model bit-exactly.
//  i_start with i_d = 0, then i_d = 13 -> o_err pulses twice. o_busy stays 0. No ready asserted.
//  BYTEDECODE_DECOMPRESS_EN: d=1, x=1 -> 1665; d=4, x=15 -> 3121; d=10, x=0 -> 0.
//  i_rst asserted after 7 input beats of a d=5 run -> all outputs 0 next cycle.
//    A new d=5 run then decodes correctly.

Source files
------------

// File: rtl/bytedecode_stream_pkg.sv
// -----------------------------------------------------------------------------
// bytedecode_stream_pkg
// Shared ML-KEM constants, FSM state encoding and small helpers for the
// streaming ByteDecode_d block.
//   KYBER_Q    : ML-KEM modulus (3329)
//   KYBER_N    : coefficients per polynomial (256)
//   KYBER_DMAX : widest legal coefficient width (12)
// -----------------------------------------------------------------------------
package bytedecode_stream_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int KYBER_DMAX = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // d is legal in 1..KYBER_DMAX
  function automatic logic d_legal(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(KYBER_DMAX));
  endfunction

  // Low-d-bit mask inside a 12-bit lane
  function automatic logic [11:0] d_mask(input logic [3:0] d);
    return 12'hFFF >> (4'd12 - d);
  endfunction

endpackage

// File: rtl/bytedecode_stream_decompress_lane.sv
// -----------------------------------------------------------------------------
// decompress_lane
// Combinational ML-KEM Decompress_d for one coefficient lane:
//   y = (x*KYBER_Q + 2^(d-1)) >> d   for d < 12
//   y = x                            for d == 12
// Only instantiated by bytedecode_stream when BYTEDECODE_DECOMPRESS_EN is
// defined.
// Ports:
//   x_i [11:0]   raw d-bit coefficient (upper bits zero)
//   d_i [3:0]    bits per coefficient
//   y_o [CW-1:0] decompressed coefficient, zero-extended
// -----------------------------------------------------------------------------
module decompress_lane
  import bytedecode_stream_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic [11:0]   x_i,
  input  logic [3:0]    d_i,
  output logic [CW-1:0] y_o
);

  // x < 2^12 and Q < 2^12, so 24 bits hold the product plus rounding term
  logic [23:0] prod_s;
  logic [23:0] round_s;
  logic [23:0] sum_s;

  // Multiply, add half-LSB rounding term, scale down by 2^d
  always_comb begin
    prod_s  = 24'(x_i) * 24'(KYBER_Q);
    round_s = 24'd1 << (d_i - 4'd1);
    sum_s   = prod_s + round_s;
    if (d_i >= 4'(KYBER_DMAX)) begin
      y_o = CW'(x_i);
    end else begin
      y_o = CW'(sum_s >> d_i);
    end
  end

endmodule

// File: rtl/bytedecode_stream.sv
// -----------------------------------------------------------------------------
// bytedecode_stream
// Streaming ML-KEM ByteDecode_d: unpacks a packed little-endian bit stream
// into NCOEF d-bit coefficients (d = 1..12), NC lanes per output beat, with
// valid/ready on both the input and output sides.
//
// Optional feature macro: BYTEDECODE_DECOMPRESS_EN
//   defined     : each lane carries Decompress_d(x) (x unchanged for d == 12)
//   not defined : each lane carries raw x, zero-extended to CW bits
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start, i_d      start one polynomial decode with d bits per coefficient
//   i_ibytes*         packed input words (byte k at [8k+7:8k], LSB-first)
//   o_ibytes_ready    input word accepted on valid & ready
//   o_coeffs*         NC lanes of CW bits, lane k = coefficient base+k
//   i_coeffs_ready    downstream ready
//   o_busy            decode in progress
//   o_done            one-cycle pulse after the last output handshake
//   o_err             one-cycle pulse on a start with illegal d
// -----------------------------------------------------------------------------
module bytedecode_stream
  import bytedecode_stream_pkg::*;
#(
  parameter int IW    = 64,
  parameter int NC    = 4,
  parameter int CW    = 12,
  parameter int NCOEF = KYBER_N
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_d,
  input  logic [IW-1:0]    i_ibytes,
  input  logic             i_ibytes_valid,
  output logic             o_ibytes_ready,
  output logic [NC*CW-1:0] o_coeffs,
  output logic             o_coeffs_valid,
  input  logic             i_coeffs_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  // One full input word plus one full beat at the widest d always fits,
  // so a pop can never be blocked by a push and vice versa.
  localparam int BUFW  = IW + NC * KYBER_DMAX;
  localparam int FW    = $clog2(BUFW + 1);
  localparam int ICW   = $clog2(NCOEF * KYBER_DMAX / 8 + 1);
  localparam int NBEAT = NCOEF / NC;
  localparam int OCW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  state_e             state_q,   state_d;
  logic [3:0]         d_q,       d_d;
  logic [FW-1:0]      fill_q,    fill_d;
  logic [BUFW-1:0]    buf_q,     buf_d;
  logic [ICW-1:0]     in_cnt_q,  in_cnt_d;
  logic [OCW-1:0]     out_cnt_q, out_cnt_d;
  logic               last_q,    last_d;
  logic [NC*CW-1:0]   coeffs_q,  coeffs_d;
  logic               valid_q,   valid_d;
  logic               err_q,     err_d;

  logic [FW-1:0]      pop_bits_s;
  logic [ICW-1:0]     in_lim_s;
  logic               pop_s;
  logic               room_s;
  logic               ready_s;
  logic               push_s;
  logic [BUFW-1:0]    buf_tmp_s;
  logic [FW-1:0]      fill_tmp_s;
  logic [NC*CW-1:0]   lanes_s;

  assign pop_bits_s = FW'(NC) * FW'(d_q);
  assign in_lim_s   = ICW'((NCOEF * 32'(d_q)) / IW);

  // last_q blocks any further load once the final beat has been taken
  assign pop_s = (state_q == S_RUN) && !last_q && (fill_q >= pop_bits_s) &&
                 (!valid_q || i_coeffs_ready);

  // Room is judged after this cycle's pop, if any
  assign room_s = (32'(fill_q) + 32'(IW)) <=
                  (32'(BUFW) - (pop_s ? 32'(pop_bits_s) : 32'd0));

  assign ready_s = (state_q == S_RUN) && (in_cnt_q < in_lim_s) && room_s;
  assign push_s  = i_ibytes_valid && ready_s;

  // Lane extraction straight from the buffer LSBs
  for (genvar k = 0; k < NC; k++) begin : g_lane
    logic [11:0] raw_s;
    assign raw_s = 12'(buf_q >> (32'(k) * 32'(d_q))) & d_mask(d_q);
`ifdef BYTEDECODE_DECOMPRESS_EN
    decompress_lane #(.CW(CW)) u_lane (
      .x_i (raw_s),
      .d_i (d_q),
      .y_o (lanes_s[k*CW +: CW])
    );
`else
    assign lanes_s[k*CW +: CW] = CW'(raw_s);
`endif
  end

  // Next-state logic: FSM, bit buffer, counters and output beat register
  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    fill_d     = fill_q;
    buf_d      = buf_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    last_d     = last_q;
    coeffs_d   = coeffs_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    buf_tmp_s  = buf_q;
    fill_tmp_s = fill_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (d_legal(i_d)) begin
            state_d   = S_RUN;
            d_d       = i_d;
            fill_d    = '0;
            buf_d     = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            last_d    = 1'b0;
            valid_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // Bits above fill are kept zero, so the push can simply be OR'ed in
        if (pop_s) begin
          buf_tmp_s  = buf_q >> pop_bits_s;
          fill_tmp_s = fill_q - pop_bits_s;
        end else begin
          buf_tmp_s  = buf_q;
          fill_tmp_s = fill_q;
        end
        if (push_s) begin
          buf_tmp_s  = buf_tmp_s | (BUFW'(i_ibytes) << fill_tmp_s);
          fill_tmp_s = fill_tmp_s + FW'(IW);
          in_cnt_d   = in_cnt_q + ICW'(1);
        end else begin
          in_cnt_d   = in_cnt_q;
        end
        buf_d  = buf_tmp_s;
        fill_d = fill_tmp_s;

        if (pop_s) begin
          coeffs_d = lanes_s;
          valid_d  = 1'b1;
          if (out_cnt_q == OCW'(NBEAT - 1)) begin
            last_d = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + OCW'(1);
          end
        end else if (i_coeffs_ready) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end

        // Once the last beat is loaded, the next handshake ends the run
        if (last_q && valid_q && i_coeffs_ready) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      d_q       <= 4'd0;
      fill_q    <= '0;
      buf_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      last_q    <= 1'b0;
      coeffs_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      last_q    <= last_d;
      coeffs_q  <= coeffs_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign o_ibytes_ready = ready_s;
  assign o_coeffs       = coeffs_q;
  assign o_coeffs_valid = valid_q;
  assign o_busy         = (state_q == S_RUN);
  assign o_done         = (state_q == S_DONE);
  assign o_err          = err_q;

endmodule

// File: tb/tb_bytedecode_stream.sv
// -----------------------------------------------------------------------------
// tb_bytedecode_stream
// Directed self-checking bench for bytedecode_stream (default build: raw lanes).
// -----------------------------------------------------------------------------
module tb_bytedecode_stream;

  localparam int IW    = 64;
  localparam int NC    = 4;
  localparam int CW    = 12;
  localparam int NCOEF = 256;
  localparam int NBEAT = NCOEF / NC;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [3:0]       i_d;
  logic [IW-1:0]    i_ibytes;
  logic             i_ibytes_valid;
  logic             o_ibytes_ready;
  logic [NC*CW-1:0] o_coeffs;
  logic             o_coeffs_valid;
  logic             i_coeffs_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  always #5 i_clk = ~i_clk;

  bytedecode_stream #(.IW(IW), .NC(NC), .CW(CW), .NCOEF(NCOEF)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_d            (i_d),
    .i_ibytes       (i_ibytes),
    .i_ibytes_valid (i_ibytes_valid),
    .o_ibytes_ready (o_ibytes_ready),
    .o_coeffs       (o_coeffs),
    .o_coeffs_valid (o_coeffs_valid),
    .i_coeffs_ready (i_coeffs_ready),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0]       stream [384];
  logic [NC*CW-1:0] first_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: coefficient idx is stream bits [idx*d +: d], LSB-first
  function automatic logic [11:0] model_coef(input int d, input int idx);
    logic [11:0] v;
    v = 12'd0;
    for (int j = 0; j < d; j++) begin
      int b;
      b = idx * d + j;
      v[j] = stream[b / 8][b % 8];
    end
    return v;
  endfunction

  function automatic logic [NC*CW-1:0] model_beat(input int d, input int beat);
    logic [NC*CW-1:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[k*CW +: CW] = model_coef(d, beat * NC + k);
    return v;
  endfunction

  function automatic logic [IW-1:0] word_of(input int w);
    logic [IW-1:0] v;
    v = '0;
    for (int b = 0; b < IW / 8; b++) v[8*b +: 8] = stream[w * (IW / 8) + b];
    return v;
  endfunction

  function automatic logic [5:0] outs_flat();
    return {o_ibytes_ready, o_coeffs_valid, o_busy, o_done, o_err, |o_coeffs};
  endfunction

  // Start a decode and stream data; optionally stall output or abort early
  task automatic run_poly(input int d, input int stall_at, input int abort_in);
    int nwords;
    int n_in;
    int n_out;
    int cyc;
    int stall_left;
    int stall_bad;
    int saw_full;
    bit stalled;
    logic [NC*CW-1:0] held;
    nwords = NCOEF * d / IW;
    n_in = 0; n_out = 0; cyc = 0; stall_left = 0; stall_bad = 0; saw_full = 0;
    stalled = 1'b0; held = '0;

    @(negedge i_clk);
    i_start = 1'b1;
    i_d     = 4'(d);
    @(negedge i_clk);
    i_start = 1'b0;

    while (n_out < NBEAT && cyc < 5000) begin
      if (abort_in >= 0 && n_in >= abort_in) break;
      i_ibytes_valid = (n_in < nwords);
      i_ibytes       = (n_in < nwords) ? word_of(n_in) : '0;
      if (stall_at >= 0 && !stalled && n_out == stall_at && o_coeffs_valid) begin
        stalled    = 1'b1;
        stall_left = 10;
        held       = o_coeffs;
      end
      i_coeffs_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        if (!(o_coeffs_valid === 1'b1 && o_coeffs === held)) stall_bad++;
        if (i_ibytes_valid && !o_ibytes_ready) saw_full = 1;
        stall_left--;
      end
      if (o_coeffs_valid && i_coeffs_ready) begin
        if (n_out == 0) first_beat = o_coeffs;
        check($sformatf("d%0d_beat%0d", d, n_out), 64'(o_coeffs), 64'(model_beat(d, n_out)));
        n_out++;
      end
      if (i_ibytes_valid && o_ibytes_ready) n_in++;
      @(negedge i_clk);
      cyc++;
    end
    i_ibytes_valid = 1'b0;
    i_coeffs_ready = 1'b1;

    if (abort_in < 0) begin
      check($sformatf("d%0d_in_beats", d), 64'(n_in), 64'(nwords));
      check($sformatf("d%0d_out_beats", d), 64'(n_out), 64'(NBEAT));
      check($sformatf("d%0d_done_hi", d), {62'd0, o_done, o_busy}, 64'd2);
      @(negedge i_clk);
      check($sformatf("d%0d_done_lo", d), {62'd0, o_done, o_busy}, 64'd0);
    end
    if (stall_at >= 0) begin
      check("stall_hold", 64'(stall_bad), 64'd0);
      check("stall_ready_drop", 64'(saw_full), 64'd1);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_d = 4'd0; i_ibytes = '0;
    i_ibytes_valid = 1'b0; i_coeffs_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("reset_outputs", 64'(outs_flat()), 64'd0);

    // Illegal d: two err pulses, never busy, never ready
    i_start = 1'b1; i_d = 4'd0;
    @(negedge i_clk);
    i_start = 1'b0;
    check("err_d0_pulse", {61'd0, o_err, o_busy, o_ibytes_ready}, 64'd4);
    @(negedge i_clk);
    check("err_d0_clear", {61'd0, o_err, o_busy, o_ibytes_ready}, 64'd0);
    i_start = 1'b1; i_d = 4'd13;
    @(negedge i_clk);
    i_start = 1'b0;
    check("err_d13_pulse", {61'd0, o_err, o_busy, o_ibytes_ready}, 64'd4);
    @(negedge i_clk);
    check("err_d13_clear", {61'd0, o_err, o_busy, o_ibytes_ready}, 64'd0);

    // d = 4: first word 21 43 .. gives lanes 1,2,3,4
    for (int i = 0; i < 384; i++) stream[i] = 8'($urandom_range(0, 255));
    stream[0] = 8'h21; stream[1] = 8'h43;
    run_poly(4, -1, -1);
    check("d4_first_beat", 64'(first_beat), 64'h0000_0040_0300_2001);

    // d = 12: bytes 01 23 45 give 0x301, 0x452
    for (int i = 0; i < 384; i++) stream[i] = 8'($urandom_range(0, 255));
    stream[0] = 8'h01; stream[1] = 8'h23; stream[2] = 8'h45;
    run_poly(12, -1, -1);
    check("d12_coeff0", 64'(first_beat[11:0]), 64'h301);
    check("d12_coeff1", 64'(first_beat[23:12]), 64'h452);

    // d = 11 with a 10-cycle output stall mid-run
    for (int i = 0; i < 384; i++) stream[i] = 8'($urandom_range(0, 255));
    run_poly(11, 20, -1);

    // d = 5 aborted by reset after 7 input beats, then a clean d = 5 run
    for (int i = 0; i < 384; i++) stream[i] = 8'($urandom_range(0, 255));
    run_poly(5, -1, 7);
    check("abort_busy_before", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("abort_outputs_zero", 64'(outs_flat()), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("abort_idle", {62'd0, o_busy, o_done}, 64'd0);
    run_poly(5, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
